isa_dispatch: RTL and testbench

Parametrised instruction sequencer for CryptoCore builds with several ComputeCore instances. It holds a host-loaded program in local memory and, on start, fetches and dispatches each instruction to the core it selects. It tracks per-core busy state from done pulses, supports barrier and end markers, and reports completion, errors and a run cycle count to the host AXI status registers.

---
 rtl/isa_dispatch.sv | 149 ++++++++++++++
 tb/tb_isa_dispatch.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isa_dispatch.sv
// rtl/isa_dispatch.sv - instruction sequencer dispatching a host-loaded program to N compute cores
module isa_dispatch #(
    parameter int LOG_COMMAND = 8,
    parameter int N_CORES     = 2,
    parameter int LOG_DEPTH   = 5,
    parameter int CYCLE_W     = 31
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           prog_we,
    input  logic [LOG_DEPTH-1:0]           prog_addr,
    input  logic [63:0]                    prog_data,
    input  logic [N_CORES-1:0]             core_done,
    output logic [N_CORES*LOG_COMMAND-1:0] command_out,
    output logic [N_CORES-1:0]             command_we,
    output logic                           busy,
    output logic                           done_all,
    output logic                           error,
    output logic [1:0]                     err_code,
    output logic [CYCLE_W-1:0]             cycle_count
);
    localparam int MW = LOG_COMMAND + 5;
    localparam logic [LOG_DEPTH-1:0] LAST_PC = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_DRAIN, S_DONE, S_ERROR
    } state_t;

    state_t                 state, state_nx;
    logic                   start_q;
    logic [LOG_DEPTH-1:0]   pc;
    logic [N_CORES-1:0]     core_busy;
    logic [1:0]             err_nx;
    logic                   accept, issue, spurious;
    logic [N_CORES-1:0]     sel_onehot;

    // Only the decoded fields are stored: {end, barrier, select, command}
    logic [MW-1:0]          mem [2**LOG_DEPTH];
    logic [MW-1:0]          word_q;
    logic                   unused_bits;

    logic [LOG_COMMAND-1:0] w_cmd;
    logic [2:0]             w_sel;
    logic                   w_bar, w_end;

    assign unused_bits = ^prog_data;
    assign w_cmd = word_q[LOG_COMMAND-1:0];
    assign w_sel = word_q[LOG_COMMAND+2:LOG_COMMAND];
    assign w_bar = word_q[MW-2];
    assign w_end = word_q[MW-1];

    assign busy     = (state == S_FETCH) || (state == S_ISSUE) || (state == S_DRAIN);
    assign done_all = (state == S_DONE);
    assign error    = (state == S_ERROR);

    always_ff @(posedge clk) begin
        if (prog_we && !busy)
            mem[prog_addr] <= {prog_data[63], prog_data[62], prog_data[10:8],
                               prog_data[LOG_COMMAND-1:0]};
        if (state == S_FETCH)
            word_q <= mem[pc];
    end

    always_comb begin
        sel_onehot = '0;
        for (int c = 0; c < N_CORES; c++)
            sel_onehot[c] = (w_sel == 3'(c));
    end

    always_comb begin
        state_nx = state;
        err_nx   = err_code;
        accept   = 1'b0;
        issue    = 1'b0;
        spurious = busy && (|(core_done & ~core_busy));
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start && !start_q) begin
                    accept   = 1'b1;
                    state_nx = S_FETCH;
                    err_nx   = 2'd0;
                end
            end
            S_FETCH: state_nx = S_ISSUE;
            S_ISSUE: begin
                // Decisions use core_busy from the start of the cycle, so a core
                // is never re-issued in the same cycle its done arrives.
                if (w_end) begin
                    state_nx = (core_busy == '0) ? S_DONE : S_DRAIN;
                end else if (sel_onehot == '0) begin
                    state_nx = S_ERROR;
                    err_nx   = 2'd1;
                end else if (!((w_bar && (core_busy != '0)) || ((core_busy & sel_onehot) != '0))) begin
                    issue = 1'b1;
                    if (pc == LAST_PC) begin
                        state_nx = S_ERROR;
                        err_nx   = 2'd2;
                    end else begin
                        state_nx = S_FETCH;
                    end
                end
            end
            S_DRAIN: begin
                if ((core_busy & ~core_done) == '0)
                    state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (spurious) begin
            issue    = 1'b0;
            state_nx = S_ERROR;
            err_nx   = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            start_q     <= 1'b0;
            pc          <= '0;
            core_busy   <= '0;
            command_out <= '0;
            command_we  <= '0;
            err_code    <= 2'd0;
            cycle_count <= '0;
        end else begin
            state      <= state_nx;
            start_q    <= start;
            err_code   <= err_nx;
            command_we <= issue ? sel_onehot : '0;
            if (accept) begin
                pc          <= '0;
                cycle_count <= '0;
                core_busy   <= '0;
            end else if (busy) begin
                core_busy <= (core_busy & ~core_done) | (issue ? sel_onehot : '0);
                if (cycle_count != '1)
                    cycle_count <= cycle_count + 1'b1;
            end
            if (issue) begin
                pc <= pc + 1'b1;
                for (int c = 0; c < N_CORES; c++)
                    if (sel_onehot[c])
                        command_out[c*LOG_COMMAND +: LOG_COMMAND] <= w_cmd;
            end
        end
    end
endmodule

// File: tb/tb_isa_dispatch.sv
// tb/tb_isa_dispatch.sv - scoreboard bench for isa_dispatch
module tb_isa_dispatch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [63:0] prog_data = '0;
    logic [1:0]  core_done = '0;
    logic [15:0] command_out;
    logic [1:0]  command_we;
    logic        busy, done_all, error;
    logic [1:0]  err_code;
    logic [30:0] cycle_count;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int base = 0;

    typedef struct { int core; int cmd; int edge_rel; } sb_t;
    sb_t exp_q[$];
    sb_t got;

    isa_dispatch dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .core_done(core_done),
        .command_out(command_out), .command_we(command_we), .busy(busy),
        .done_all(done_all), .error(error), .err_code(err_code),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #50000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "timeout");
    end

    // Every strobe must match the oldest expected dispatch: core, command and edge.
    always @(negedge clk) begin
        if (command_we != 2'b00) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL strobe_unexpected: got we=%b out=%h at edge %0d, required no strobe",
                         command_we, command_out, cyc - base);
            end else begin
                got = exp_q.pop_front();
                if (command_we !== (2'b01 << got.core) ||
                    command_out[got.core*8 +: 8] !== got.cmd[7:0] ||
                    cyc !== base + got.edge_rel) begin
                    tests_failed++;
                    $display("FAIL strobe: got we=%b cmd=%h edge=%0d, required core=%0d cmd=%h edge=%0d",
                             command_we, command_out[got.core*8 +: 8], cyc - base,
                             got.core, got.cmd, got.edge_rel);
                end
            end
        end
    end

    function automatic logic [63:0] mkw(input logic e, input logic b,
                                        input logic [2:0] s, input logic [7:0] c);
        mkw = '0;
        mkw[63] = e;
        mkw[62] = b;
        mkw[10:8] = s;
        mkw[7:0] = c;
    endfunction

    task automatic write_word(input int a, input logic [63:0] d);
        prog_we = 1'b1; prog_addr = 5'(a); prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        base = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic goto_edge(input int e);
        while (cyc < base + e) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push(input int core, input int cmd, input int e);
        sb_t s;
        s.core = core; s.cmd = cmd; s.edge_rel = e;
        exp_q.push_back(s);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({command_out, command_we, busy, done_all, error, err_code} !== 23'd0 || cycle_count !== 31'd0) begin
            tests_failed++;
            $display("FAIL reset_values: got out=%h we=%b busy=%b done=%b err=%b code=%0d cnt=%0d, required all zero",
                     command_out, command_we, busy, done_all, error, err_code, cycle_count);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_two_cores();
        write_word(0, mkw(0, 0, 0, 8'h11));
        write_word(1, mkw(0, 0, 1, 8'h22));
        write_word(2, mkw(1, 0, 0, 8'h00));
        push(0, 'h11, 2);
        push(1, 'h22, 4);
        launch();
        goto_edge(7);
        tests_run++;
        if (busy !== 1'b1 || done_all !== 1'b0) begin
            tests_failed++;
            $display("FAIL two_drain: got busy=%b done=%b, required busy=1 done=0", busy, done_all);
        end
        goto_edge(10);
        core_done = 2'b11;
        @(posedge clk); #1;
        core_done = 2'b00;
        tests_run++;
        if (done_all !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || cycle_count !== 31'd11) begin
            tests_failed++;
            $display("FAIL two_done: got done=%b busy=%b err=%b cnt=%0d, required done=1 busy=0 err=0 cnt=11",
                     done_all, busy, error, cycle_count);
        end
        tests_run++;
        if (command_out !== 16'h2211 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL two_slices: got out=%h pending=%0d, required out=2211 pending=0",
                     command_out, exp_q.size());
        end
    endtask

    task automatic test_stall();
        write_word(0, mkw(0, 0, 0, 8'h01));
        write_word(1, mkw(0, 0, 0, 8'h02));
        write_word(2, mkw(1, 0, 0, 8'h00));
        push(0, 'h01, 2);
        push(0, 'h02, 10);
        launch();
        goto_edge(1);
        start = 1'b1;
        goto_edge(6);
        tests_run++;
        if (busy !== 1'b1 || command_we !== 2'b00) begin
            tests_failed++;
            $display("FAIL stall_hold: got busy=%b we=%b, required busy=1 we=00", busy, command_we);
        end
        goto_edge(8);
        core_done = 2'b01;
        @(posedge clk); #1;
        core_done = 2'b00;
        goto_edge(12);
        core_done = 2'b01;
        @(posedge clk); #1;
        core_done = 2'b00;
        tests_run++;
        if (done_all !== 1'b1 || error !== 1'b0 || cycle_count !== 31'd13 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL stall_done: got done=%b err=%b cnt=%0d pending=%0d, required done=1 err=0 cnt=13 pending=0",
                     done_all, error, cycle_count, exp_q.size());
        end
        goto_edge(16);
        tests_run++;
        if (done_all !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_held: got done=%b busy=%b, required done=1 busy=0", done_all, busy);
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_barrier();
        write_word(0, mkw(0, 0, 0, 8'h05));
        write_word(1, mkw(0, 1, 1, 8'h06));
        write_word(2, mkw(1, 0, 0, 8'h00));
        push(0, 'h05, 2);
        push(1, 'h06, 8);
        launch();
        goto_edge(6);
        core_done = 2'b01;
        @(posedge clk); #1;
        core_done = 2'b00;
        goto_edge(10);
        core_done = 2'b10;
        @(posedge clk); #1;
        core_done = 2'b00;
        tests_run++;
        if (done_all !== 1'b1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL barrier_done: got done=%b pending=%0d, required done=1 pending=0",
                     done_all, exp_q.size());
        end
        push(0, 'h05, 2);
        launch();
        goto_edge(4);
        core_done = 2'b10;
        @(posedge clk); #1;
        core_done = 2'b00;
        tests_run++;
        if (error !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0 || done_all !== 1'b0) begin
            tests_failed++;
            $display("FAIL spurious_done: got err=%b code=%0d busy=%b done=%b, required err=1 code=3 busy=0 done=0",
                     error, err_code, busy, done_all);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_bad_select();
        write_word(0, mkw(0, 0, 7, 8'h33));
        launch();
        goto_edge(2);
        tests_run++;
        if (error !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0 || command_we !== 2'b00 || cycle_count !== 31'd2) begin
            tests_failed++;
            $display("FAIL bad_select: got err=%b code=%0d busy=%b we=%b cnt=%0d, required err=1 code=1 busy=0 we=00 cnt=2",
                     error, err_code, busy, command_we, cycle_count);
        end
        write_word(0, mkw(0, 0, 1, 8'h44));
        write_word(1, mkw(1, 0, 0, 8'h00));
        push(1, 'h44, 2);
        launch();
        goto_edge(4);
        core_done = 2'b10;
        @(posedge clk); #1;
        core_done = 2'b00;
        tests_run++;
        if (done_all !== 1'b1 || err_code !== 2'd0 || error !== 1'b0 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL restart: got done=%b code=%0d err=%b pending=%0d, required done=1 code=0 err=0 pending=0",
                     done_all, err_code, error, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 32; k++)
            write_word(k, mkw(0, 0, 3'(k % 2), 8'(k + 'h80)));
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 32; k++)
                push(k % 2, k + 'h80, 2 + 2 * k);
            launch();
            for (int k = 0; k < 32; k++) begin
                goto_edge(2 + 2 * k);
                prog_we = 1'b0;
                core_done = (k % 2 == 1) ? 2'b10 : 2'b01;
                @(posedge clk); #1;
                core_done = 2'b00;
                if (r == 0 && k == 10) begin
                    prog_we = 1'b1; prog_addr = 5'd12; prog_data = mkw(1, 0, 0, 8'h00);
                end
            end
            tests_run++;
            if (error !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0 || cycle_count !== 31'd64 || exp_q.size() != 0) begin
                tests_failed++;
                $display("FAIL overflow_run%0d: got err=%b code=%0d busy=%b cnt=%0d pending=%0d, required err=1 code=2 busy=0 cnt=64 pending=0",
                         r, error, err_code, busy, cycle_count, exp_q.size());
            end
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_drain();
        write_word(0, mkw(0, 0, 0, 8'h5A));
        write_word(1, mkw(0, 0, 1, 8'hA5));
        write_word(2, mkw(1, 0, 0, 8'h00));
        push(0, 'h5A, 2);
        push(1, 'hA5, 4);
        launch();
        goto_edge(8);
        tests_run++;
        if (busy !== 1'b1 || command_out !== 16'hA55A) begin
            tests_failed++;
            $display("FAIL pre_reset: got busy=%b out=%h, required busy=1 out=a55a", busy, command_out);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({command_out, command_we, busy, done_all, error, err_code} !== 23'd0 || cycle_count !== 31'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got out=%h we=%b busy=%b done=%b err=%b code=%0d cnt=%0d, required all zero",
                     command_out, command_we, busy, done_all, error, err_code, cycle_count);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || command_we !== 2'b00 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got busy=%b we=%b pending=%0d, required busy=0 we=00 pending=0",
                     busy, command_we, exp_q.size());
        end
        push(0, 'h5A, 2);
        push(1, 'hA5, 4);
        launch();
        goto_edge(6);
        core_done = 2'b11;
        @(posedge clk); #1;
        core_done = 2'b00;
        tests_run++;
        if (done_all !== 1'b1 || cycle_count !== 31'd7 || command_out !== 16'hA55A || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rerun: got done=%b cnt=%0d out=%h pending=%0d, required done=1 cnt=7 out=a55a pending=0",
                     done_all, cycle_count, command_out, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_two_cores();
        test_stall();
        test_barrier();
        test_bad_select();
        test_overflow();
        test_reset_mid_drain();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
